// File: rtl/switchbox_cfg_loader_if.sv
// Bus between the fabric config port and the switch-box loader.
//   master: drives start / bit_in / bit_valid, observes everything else
//   slave : the loader; accepts the serial stream and drives the commit
//           bus (cfg_word, cfg_sel, cfg_we), status (busy, done) and the
//           sticky error flags with the failing frame address (err_box).
interface switchbox_cfg_loader_if #(
  parameter int unsigned NUM_BOXES = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned CFG_W     = 60
);
  logic                 start;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 bit_ready;
  logic [CFG_W-1:0]     cfg_word;
  logic [NUM_BOXES-1:0] cfg_sel;
  logic                 cfg_we;
  logic                 busy;
  logic                 done;
  logic                 err_parity;
  logic                 err_addr;
  logic                 err_contention;
  logic [ADDR_W-1:0]    err_box;

  modport master (
    output start, bit_in, bit_valid,
    input  bit_ready, cfg_word, cfg_sel, cfg_we, busy, done,
           err_parity, err_addr, err_contention, err_box
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output bit_ready, cfg_word, cfg_sel, cfg_we, busy, done,
           err_parity, err_addr, err_contention, err_box
  );
endinterface

// File: rtl/switchbox_cfg_loader.sv
// Serial configuration loader for a chain of switch boxes.
// Deserialises framed bitstreams (ADDR_W address bits, 60 data bits MSB
// first, one even-parity bit), validates address range, parity and driver
// contention, then commits each word to its box with a one-cycle strobe.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - slave side of switchbox_cfg_loader_if (stream in, commit/status out)
module switchbox_cfg_loader #(
  parameter int unsigned NUM_BOXES = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned CFG_W     = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  switchbox_cfg_loader_if.slave bus
);

  localparam int unsigned SR_W  = ADDR_W + CFG_W;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_PAR,
    S_CHECK,
    S_COMMIT,
    S_DONE,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic                par_q, par_d;
  logic [CFG_W-1:0]    word_q, word_d;
  logic                err_par_q, err_par_d;
  logic                err_addr_q, err_addr_d;
  logic                err_cont_q, err_cont_d;
  logic [ADDR_W-1:0]   err_box_q, err_box_d;

  logic                xfer;
  logic                ready;
  logic [ADDR_W-1:0]   addr;
  logic [CFG_W-1:0]    data;
  logic                addr_bad;
  logic                par_bad;
  logic                contention;
  logic [SR_W-1:0]     sr_shift;

  // Address bits enter first, so after a full frame the address sits in the
  // top ADDR_W bits and data bit 59 directly below it.
  assign addr     = sr_q[SR_W-1:CFG_W];
  assign data     = sr_q[CFG_W-1:0];
  assign sr_shift = {sr_q[SR_W-2:0], bus.bit_in};

  assign ready    = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_PAR);
  assign xfer     = ready && bus.bit_valid;

  assign addr_bad = (32'(addr) >= NUM_BOXES);
  assign par_bad  = ((^sr_q) != par_q);

  function automatic logic multi3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Four sides per lane; each side may be driven by at most one source.
  always_comb begin
    contention = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      contention |= multi3(data[6*k+1], data[6*k+2],  data[6*k+4]);
      contention |= multi3(data[6*k],   data[30+4*k], data[32+4*k]);
      contention |= multi3(data[6*k+3], data[31+4*k], data[50+2*k]);
      contention |= multi3(data[6*k+5], data[33+4*k], data[51+2*k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      sr_q        <= '0;
      par_q       <= 1'b0;
      word_q      <= '0;
      err_par_q   <= 1'b0;
      err_addr_q  <= 1'b0;
      err_cont_q  <= 1'b0;
      err_box_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      sr_q        <= sr_d;
      par_q       <= par_d;
      word_q      <= word_d;
      err_par_q   <= err_par_d;
      err_addr_q  <= err_addr_d;
      err_cont_q  <= err_cont_d;
      err_box_q   <= err_box_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    sr_d        = sr_q;
    par_d       = par_q;
    word_d      = word_q;
    err_par_d   = err_par_q;
    err_addr_d  = err_addr_q;
    err_cont_d  = err_cont_q;
    err_box_d   = err_box_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_ADDR;
          frame_cnt_d = '0;
          bit_cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          sr_d = sr_shift;
          if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          sr_d = sr_shift;
          if (bit_cnt_q == CNT_W'(CFG_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_PAR;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (xfer) begin
          par_d   = bus.bit_in;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (addr_bad) begin
          err_addr_d = 1'b1;
          err_box_d  = addr;
          state_d    = S_ERROR;
        end else if (par_bad) begin
          err_par_d  = 1'b1;
          err_box_d  = addr;
          state_d    = S_ERROR;
        end else if (contention) begin
          err_cont_d = 1'b1;
          err_box_d  = addr;
          state_d    = S_ERROR;
        end else begin
          // Latched here so cfg_word is valid throughout COMMIT and holds after.
          word_d  = data;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (frame_cnt_q == ADDR_W'(NUM_BOXES - 1)) begin
          state_d = S_DONE;
        end else begin
          frame_cnt_d = frame_cnt_q + ADDR_W'(1);
          state_d     = S_ADDR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (bus.start) begin
          err_par_d   = 1'b0;
          err_addr_d  = 1'b0;
          err_cont_d  = 1'b0;
          err_box_d   = '0;
          frame_cnt_d = '0;
          bit_cnt_d   = '0;
          state_d     = S_ADDR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.cfg_sel = '0;
    if (state_q == S_COMMIT) begin
      for (int unsigned i = 0; i < NUM_BOXES; i++) begin
        bus.cfg_sel[i] = (32'(addr) == i);
      end
    end
  end

  assign bus.bit_ready      = ready;
  assign bus.cfg_word       = word_q;
  assign bus.cfg_we         = (state_q == S_COMMIT);
  assign bus.busy           = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign bus.done           = (state_q == S_DONE);
  assign bus.err_parity     = err_par_q;
  assign bus.err_addr       = err_addr_q;
  assign bus.err_contention = err_cont_q;
  assign bus.err_box        = err_box_q;

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Bench for switchbox_cfg_loader: a 4-box and a 3-box instance share one
// stimulus stream; expectations come from tables and a frame-level model.
module tb_switchbox_cfg_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned CW = 60;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  switchbox_cfg_loader_if #(.NUM_BOXES(4), .ADDR_W(AW), .CFG_W(CW)) b4 ();
  switchbox_cfg_loader_if #(.NUM_BOXES(3), .ADDR_W(AW), .CFG_W(CW)) b3 ();

  assign b4.start = start;
  assign b4.bit_in = bit_in;
  assign b4.bit_valid = bit_valid;
  assign b3.start = start;
  assign b3.bit_in = bit_in;
  assign b3.bit_valid = bit_valid;

  switchbox_cfg_loader #(.NUM_BOXES(4), .ADDR_W(AW), .CFG_W(CW)) dut4 (
    .clk(clk), .reset(reset), .bus(b4));
  switchbox_cfg_loader #(.NUM_BOXES(3), .ADDR_W(AW), .CFG_W(CW)) dut3 (
    .clk(clk), .reset(reset), .bus(b3));

  typedef struct { logic [3:0] sel; logic [CW-1:0] word; } cmt_t;
  typedef struct { logic [AW-1:0] a; logic [CW-1:0] w; bit bp; } frm_t;
  typedef struct {
    logic [AW-1:0] a; logic [CW-1:0] w; bit bp;
    bit we; logic [3:0] sel; bit ea; bit ep; bit ec;
  } vec_t;

  cmt_t cq[$];
  int done_cnt = 0;
  int unsigned done_cyc = 0;
  int b3_we = 0;
  bit abort = 1'b0;
  frm_t sess[4];

  always @(negedge clk) begin
    cmt_t c;
    if (b4.cfg_we === 1'b1) begin
      c.sel = b4.cfg_sel;
      c.word = b4.cfg_word;
      cq.push_back(c);
    end
    if (b4.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (b3.cfg_we === 1'b1) b3_we++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: outcome of one frame from the address/parity/
  // contention rules. 0 commit, 1 address, 2 parity, 3 contention.
  function automatic int outcome(input logic [AW-1:0] a, input logic [CW-1:0] w,
                                 input bit bp, input int nb);
    int grp[4][3];
    int n;
    if (int'(a) >= nb) return 1;
    if (bp) return 2;
    for (int k = 0; k < 5; k++) begin
      grp = '{'{6*k+1, 6*k+2, 6*k+4}, '{6*k, 30+4*k, 32+4*k},
              '{6*k+3, 31+4*k, 50+2*k}, '{6*k+5, 33+4*k, 51+2*k}};
      for (int g = 0; g < 4; g++) begin
        n = 0;
        for (int j = 0; j < 3; j++) n += w[grp[g][j]] ? 1 : 0;
        if (n > 1) return 3;
      end
    end
    return 0;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    cycles(2);
    reset = 1'b1;
    @(negedge clk);
    cq.delete();
    done_cnt = 0;
    b3_we = 0;
    abort = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one bit; returns at the negedge before the edge that accepts it.
  task automatic send_bit(input logic b, input bit gap, output int unsigned acc);
    int unsigned guard;
    acc = 0;
    if (abort) return;
    if (gap) begin
      @(negedge clk);
      bit_valid = 1'b0;
    end
    @(negedge clk);
    bit_in = b;
    bit_valid = 1'b1;
    guard = 0;
    while (b4.bit_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      abort = 1'b1;
      bit_valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL bit_ready_timeout waited=%0d required<200", guard);
    end
    acc = cyc;
  endtask

  // gapmode: 0 none, 1 alternate valid 0/1, 2 random gaps
  task automatic send_frame(input logic [AW-1:0] a, input logic [CW-1:0] w, input bit bp,
                            input int gapmode, output int unsigned first_acc);
    logic [AW+CW-1:0] body;
    logic p;
    int unsigned acc;
    bit g;
    body = {a, w};
    p = (^body) ^ bp;
    first_acc = 0;
    for (int i = AW+CW; i >= 0; i--) begin
      g = (gapmode == 1) ? 1'b1 : (gapmode == 2) ? ($urandom % 4 == 0) : 1'b0;
      send_bit((i == AW+CW) ? body[AW+CW-1] : (i == 0 ? p : body[i-1]), g, acc);
      if (i == AW+CW) first_acc = acc;
    end
  endtask

  task automatic run_session(input int gapmode, input bit chk_lat, input string tag);
    logic [3:0] esel[4];
    logic [CW-1:0] eword[4];
    int nexp, ek, k, guard;
    logic [AW-1:0] eb;
    int unsigned first, acc;
    cq.delete();
    done_cnt = 0;
    abort = 1'b0;
    nexp = 0;
    ek = 0;
    eb = '0;
    first = 0;
    pulse_start();
    for (int f = 0; f < 4; f++) begin
      send_frame(sess[f].a, sess[f].w, sess[f].bp, gapmode, acc);
      if (f == 0) first = acc;
      k = outcome(sess[f].a, sess[f].w, sess[f].bp, 4);
      if (k == 0) begin
        esel[nexp] = 4'b0001 << sess[f].a;
        eword[nexp] = sess[f].w;
        nexp++;
      end else begin
        ek = k;
        eb = sess[f].a;
        break;
      end
    end
    @(negedge clk);
    bit_valid = 1'b0;
    if (ek == 0) begin
      guard = 0;
      while (done_cnt == 0 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
    end
    cycles(4);
    check({tag, "_ncommit"}, cq.size(), nexp);
    for (int i = 0; i < nexp && i < cq.size(); i++) begin
      check($sformatf("%s_sel%0d", tag, i), cq[i].sel, esel[i]);
      check($sformatf("%s_word%0d", tag, i), cq[i].word, eword[i]);
    end
    check({tag, "_done"}, done_cnt, (ek == 0) ? 1 : 0);
    check({tag, "_err_addr"}, b4.err_addr, ek == 1);
    check({tag, "_err_par"}, b4.err_parity, ek == 2);
    check({tag, "_err_cont"}, b4.err_contention, ek == 3);
    if (ek != 0) check({tag, "_err_box"}, b4.err_box, eb);
    check({tag, "_busy"}, b4.busy, 0);
    if (chk_lat && ek == 0) begin
      if (gapmode == 0) check({tag, "_latency"}, done_cyc - first, 4*65);
      else check({tag, "_latency_2x"}, (done_cyc - first >= 500) && (done_cyc - first <= 530), 1);
    end
  endtask

  initial begin
    vec_t vt[8];
    int nz;
    int unsigned acc;
    logic [63:0] r1, r2, r3, r4;

    vt[0] = '{2'd0, 60'h9,                   1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0};
    vt[1] = '{2'd2, 60'h9,                   1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    vt[2] = '{2'd1, 60'h6,                   1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vt[3] = '{2'd3, 60'h6,                   1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    vt[4] = '{2'd2, 60'h1_4000_0000_0000,    1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vt[5] = '{2'd1, 60'hC_0000_0000_0000,    1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0};
    vt[6] = '{2'd3, 60'h800_0000_0000_0000,  1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0};
    vt[7] = '{2'd0, 60'h4_0000_8000_0000,    1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};

    // Reset and idle
    cycles(2);
    check("rst_busy", b4.busy, 0);
    check("rst_ready", b4.bit_ready, 0);
    check("rst_word", b4.cfg_word, 0);
    check("rst_errbox", b4.err_box, 0);
    reset = 1'b1;
    nz = 0;
    repeat (20) begin
      @(negedge clk);
      if (b4.bit_ready | b4.cfg_we | b4.busy | b4.done | b4.err_parity | b4.err_addr |
          b4.err_contention | (|b4.cfg_word) | (|b4.cfg_sel) | (|b4.err_box)) nz++;
    end
    check("idle_quiet", nz, 0);

    // Happy path, then the same with valid toggling
    for (int i = 0; i < 4; i++) sess[i] = '{2'(i), 60'h9, 1'b0};
    run_session(0, 1'b1, "happy");
    run_session(1, 1'b1, "stall");

    // Reset in the middle of DATA
    cq.delete();
    pulse_start();
    for (int i = 0; i < 32; i++) send_bit(i < 2 ? 1'b0 : 1'b1, 1'b0, acc);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", b4.busy, 0);
    check("midrst_ready", b4.bit_ready, 0);
    check("midrst_word", b4.cfg_word, 0);
    bit_valid = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(2);
    check("midrst_no_we", cq.size(), 0);
    run_session(0, 1'b1, "after_rst");

    // Single-frame vectors, each from a fresh reset
    foreach (vt[v]) begin
      do_reset();
      pulse_start();
      send_frame(vt[v].a, vt[v].w, vt[v].bp, 0, acc);
      @(negedge clk);
      bit_valid = 1'b0;
      cycles(4);
      check($sformatf("v%0d_we", v), cq.size(), vt[v].we);
      if (vt[v].we && cq.size() > 0) begin
        check($sformatf("v%0d_sel", v), cq[0].sel, vt[v].sel);
        check($sformatf("v%0d_word", v), cq[0].word, vt[v].w);
      end
      check($sformatf("v%0d_err_addr", v), b4.err_addr, vt[v].ea);
      check($sformatf("v%0d_err_par", v), b4.err_parity, vt[v].ep);
      check($sformatf("v%0d_err_cont", v), b4.err_contention, vt[v].ec);
      if (!vt[v].we) check($sformatf("v%0d_err_box", v), b4.err_box, vt[v].a);
      check($sformatf("v%0d_busy", v), b4.busy, vt[v].we);
    end

    // Parity error then start clears the flags
    do_reset();
    pulse_start();
    send_frame(2'd2, 60'h9, 1'b1, 0, acc);
    @(negedge clk);
    bit_valid = 1'b0;
    cycles(4);
    check("perr_flag", b4.err_parity, 1);
    check("perr_box", b4.err_box, 2);
    pulse_start();
    check("clr_par", b4.err_parity, 0);
    check("clr_box", b4.err_box, 0);
    check("clr_busy", b4.busy, 1);

    // Address out of range beats bad parity on the 3-box instance
    do_reset();
    pulse_start();
    send_frame(2'd3, 60'h9, 1'b1, 0, acc);
    @(negedge clk);
    bit_valid = 1'b0;
    cycles(4);
    check("n3_err_addr", b3.err_addr, 1);
    check("n3_err_par", b3.err_parity, 0);
    check("n3_err_box", b3.err_box, 3);
    check("n3_no_we", b3_we, 0);
    check("n4_err_par", b4.err_parity, 1);

    // Randomised sessions against the frame model
    for (int s = 0; s < 10; s++) begin
      do_reset();
      for (int f = 0; f < 4; f++) begin
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        r3 = {$urandom(), $urandom()};
        r4 = {$urandom(), $urandom()};
        sess[f].a = AW'($urandom % 4);
        sess[f].w = r1[CW-1:0] & r2[CW-1:0] & r3[CW-1:0] & r4[CW-1:0];
        sess[f].bp = ($urandom % 8 == 0);
      end
      run_session((s % 2 == 1) ? 2 : 0, 1'b0, $sformatf("rnd%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
